hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and forwarding unit for the 5-stage pipeline, the successor to the current ID-stage hazard/forwarding logic. Sits in the ID stage: compares ID source registers against EX and DM destinations, drives operand-forwarding selects, load-use stalls, pipeline freeze on a slow data-memory handshake, and multi-cycle IF/ID flush after a taken branch. Keeps saturating stall/flush performance counters.

---
 rtl/hazard_fwd_unit_pkg.sv | 26 ++
 rtl/hazard_fwd_unit_if.sv | 47 ++++
 rtl/hazard_fwd_unit_sat_counter.sv | 25 ++
 rtl/hazard_fwd_unit.sv | 125 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants, FSM state type and operand-select helper for the
// ID-stage hazard detection and forwarding unit.
package hazard_fwd_unit_pkg;

    localparam logic [1:0] FWD_EX = 2'b00;
    localparam logic [1:0] FWD_DM = 2'b01;
    localparam logic [1:0] FWD_RF = 2'b10;

    // Wide enough for the largest branch penalty of 15.
    localparam int FLUSH_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    function automatic logic [1:0] fwd_sel(input logic uses, input logic ex_hit,
                                           input logic dm_hit);
        if (!uses)  return FWD_RF;
        if (ex_hit) return FWD_EX;
        if (dm_hit) return FWD_DM;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-facing signal bundle of the hazard/forwarding unit: the pipeline
// side is the master, the unit itself is the slave.
interface hazard_fwd_unit_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic              id_valid;
    logic [RA_W-1:0]   id_rs_addr;
    logic [RA_W-1:0]   id_rt_addr;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_store;
    logic              id_branch_taken;
    logic              ex_wb_en;
    logic              dm_wb_en;
    logic [RA_W-1:0]   ex_wb_addr;
    logic [RA_W-1:0]   dm_wb_addr;
    logic              ex_is_load;
    logic              dm_is_load;
    logic              dm_ready;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_flush;
    logic              bubble;
    logic              pipe_hold;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              fwd_dm;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_is_store, id_branch_taken, ex_wb_en, dm_wb_en, ex_wb_addr,
               dm_wb_addr, ex_is_load, dm_is_load, dm_ready,
        input  pc_we, if_id_we, if_id_flush, bubble, pipe_hold, fwd_a, fwd_b,
               fwd_dm, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_is_store, id_branch_taken, ex_wb_en, dm_wb_en, ex_wb_addr,
               dm_wb_addr, ex_is_load, dm_is_load, dm_ready,
        output pc_we, if_id_we, if_id_flush, bubble, pipe_hold, fwd_a, fwd_b,
               fwd_dm, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module hazard_fwd_unit_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard detection and operand forwarding: load-use stalls, freeze
// on a slow data-memory load, multi-cycle IF/ID flush after a taken branch.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    hazard_fwd_unit_if.slave bus
);
    localparam int RA_W = $clog2(NUM_REGS);

    state_t               r_state, r_ret_state;
    state_t               w_state_nx, w_ret_nx, w_mode;
    logic [FLUSH_W-1:0]   r_flush_left, w_left_nx;
    logic [RA_W-1:0]      w_rs, w_rt;
    logic                 w_rs_ex, w_rt_ex, w_rs_dm, w_rt_dm;
    logic                 w_load_use, w_miss;
    logic                 w_pc_we, w_if_id_we, w_flush, w_bubble, w_hold, w_fwd_dm;
    logic [1:0]           w_fwd_a, w_fwd_b;

    assign w_rs = bus.id_rs_addr;
    assign w_rt = bus.id_rt_addr;

    // Register 0 never matches, so all hit terms require a nonzero source.
    assign w_rs_ex = (w_rs != '0) & bus.ex_wb_en & (bus.ex_wb_addr == w_rs);
    assign w_rt_ex = (w_rt != '0) & bus.ex_wb_en & (bus.ex_wb_addr == w_rt);
    assign w_rs_dm = (w_rs != '0) & bus.dm_wb_en & (bus.dm_wb_addr == w_rs);
    assign w_rt_dm = (w_rt != '0) & bus.dm_wb_en & (bus.dm_wb_addr == w_rt);

    assign w_load_use = bus.id_valid & bus.ex_is_load &
                        ((bus.id_uses_rs & w_rs_ex) | (bus.id_uses_rt & w_rt_ex));
    assign w_miss     = bus.dm_is_load & ~bus.dm_ready;

    // MEM_WAIT behaves like the state it interrupted once the load completes.
    assign w_mode = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_ret_state  <= ST_RUN;
            r_flush_left <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_ret_state  <= w_ret_nx;
            r_flush_left <= w_left_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ret_nx   = r_ret_state;
        w_left_nx  = r_flush_left;
        w_pc_we    = 1'b1;
        w_if_id_we = 1'b1;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        w_hold     = 1'b0;
        w_fwd_a    = fwd_sel(bus.id_uses_rs, w_rs_ex & ~bus.ex_is_load, w_rs_dm);
        w_fwd_b    = fwd_sel(bus.id_uses_rt, w_rt_ex & ~bus.ex_is_load, w_rt_dm);
        w_fwd_dm   = bus.id_is_store & w_rt_ex;
        if (rst) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_bubble   = 1'b1;
            w_flush    = 1'b1;
            w_fwd_a    = FWD_RF;
            w_fwd_b    = FWD_RF;
            w_fwd_dm   = 1'b0;
            w_state_nx = ST_RUN;
            w_left_nx  = '0;
        end else if (w_miss) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_hold     = 1'b1;
            w_state_nx = ST_MEM_WAIT;
            w_ret_nx   = w_mode;
        end else if (w_load_use) begin
            w_pc_we    = 1'b0;
            w_if_id_we = 1'b0;
            w_bubble   = 1'b1;
            w_state_nx = w_mode;
        end else if (w_mode == ST_FLUSH) begin
            w_flush    = 1'b1;
            w_left_nx  = r_flush_left - 1'b1;
            w_state_nx = (r_flush_left <= FLUSH_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (bus.id_branch_taken) begin
            w_flush = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                w_state_nx = ST_FLUSH;
                w_left_nx  = FLUSH_W'(BRANCH_PENALTY - 1);
            end else begin
                w_state_nx = ST_RUN;
            end
        end else begin
            w_state_nx = ST_RUN;
        end
    end

    hazard_fwd_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (~w_pc_we),
        .o_count (bus.stall_cnt)
    );

    hazard_fwd_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_flush),
        .o_count (bus.flush_cnt)
    );

    assign bus.pc_we       = w_pc_we;
    assign bus.if_id_we    = w_if_id_we;
    assign bus.if_id_flush = w_flush;
    assign bus.bubble      = w_bubble;
    assign bus.pipe_hold   = w_hold;
    assign bus.fwd_a       = w_fwd_a;
    assign bus.fwd_b       = w_fwd_b;
    assign bus.fwd_dm      = w_fwd_dm;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed scenarios plus random
// traffic, predicted by a cycle-level behavioural model of the pipeline rules.
module tb_hazard_fwd_unit;
    localparam int NR   = 32;
    localparam int RA   = 5;
    localparam int BP   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rst;
        logic          id_valid;
        logic [RA-1:0] rs;
        logic [RA-1:0] rt;
        logic          urs;
        logic          urt;
        logic          st;
        logic          br;
        logic          exwb;
        logic [RA-1:0] exa;
        logic          exld;
        logic          dmwb;
        logic [RA-1:0] dma;
        logic          dmld;
        logic          dmrdy;
    } stim_t;

    typedef struct {
        int           tag;
        int           cyc;
        bit           chk_cnt;
        logic [4:0]   ctl;
        logic [4:0]   fwd;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q[$];

    int   m_flush_rem = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   m_known = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.RA_W(RA), .CNT_W(CW)) bus ();

    hazard_fwd_unit #(
        .NUM_REGS       (NR),
        .BRANCH_PENALTY (BP),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.id_valid = 1'b1;
        s.dmrdy    = 1'b1;
        return s;
    endfunction

    // Operand source as the pipeline sees it: newest producer wins, r0 never forwarded.
    function automatic logic [1:0] ref_fwd(input logic uses, input logic [RA-1:0] a,
                                           input stim_t s);
        if (!uses || a == 0) return 2'b10;
        if (s.exwb && !s.exld && s.exa == a) return 2'b00;
        if (s.dmwb && s.dma == a) return 2'b01;
        return 2'b10;
    endfunction

    task automatic apply(input stim_t s);
        rst                 = s.rst;
        bus.id_valid        = s.id_valid;
        bus.id_rs_addr      = s.rs;
        bus.id_rt_addr      = s.rt;
        bus.id_uses_rs      = s.urs;
        bus.id_uses_rt      = s.urt;
        bus.id_is_store     = s.st;
        bus.id_branch_taken = s.br;
        bus.ex_wb_en        = s.exwb;
        bus.ex_wb_addr      = s.exa;
        bus.ex_is_load      = s.exld;
        bus.dm_wb_en        = s.dmwb;
        bus.dm_wb_addr      = s.dma;
        bus.dm_is_load      = s.dmld;
        bus.dm_ready        = s.dmrdy;
    endtask

    task automatic step(input stim_t s, input int tag);
        exp_t e;
        logic pc, ifw, fl, bub, hold;
        bit   miss, lu, rs_hit, rt_hit;
        apply(s);
        e.tag     = tag;
        e.cyc     = cyc;
        e.chk_cnt = m_known;
        e.sc      = CW'(m_stall);
        e.fc      = CW'(m_flush);
        pc = 1'b1; ifw = 1'b1; fl = 1'b0; bub = 1'b0; hold = 1'b0;
        e.fwd = {ref_fwd(s.urs, s.rs, s), ref_fwd(s.urt, s.rt, s),
                 logic'(s.st && s.exwb && s.exa == s.rt && s.rt != 0)};
        rs_hit = s.urs && s.rs != 0 && s.exa == s.rs;
        rt_hit = s.urt && s.rt != 0 && s.exa == s.rt;
        lu     = s.id_valid && s.exld && s.exwb && (rs_hit || rt_hit);
        miss   = s.dmld && !s.dmrdy;
        if (s.rst) begin
            pc = 1'b0; ifw = 1'b0; bub = 1'b1; fl = 1'b1;
            e.fwd = 5'b10100;
        end else if (miss) begin
            pc = 1'b0; ifw = 1'b0; hold = 1'b1;
        end else if (lu) begin
            pc = 1'b0; ifw = 1'b0; bub = 1'b1;
        end else if (m_flush_rem > 0) begin
            fl = 1'b1;
            m_flush_rem--;
        end else if (s.br) begin
            fl = 1'b1;
            m_flush_rem = BP - 1;
        end
        e.ctl = {pc, ifw, fl, bub, hold};
        q.push_back(e);
        if (s.rst) begin
            m_flush_rem = 0; m_stall = 0; m_flush = 0; m_known = 1;
        end else begin
            if (!pc && m_stall < CMAX) m_stall++;
            if (fl && m_flush < CMAX) m_flush++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] act_ctl, act_fwd;
        if (q.size() > 0) begin
            e = q.pop_front();
            act_ctl = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.bubble, bus.pipe_hold};
            act_fwd = {bus.fwd_a, bus.fwd_b, bus.fwd_dm};
            n_checks++;
            if (act_ctl !== e.ctl) begin
                n_errors++;
                $display("FAIL ctrl tag=%0d cyc=%0d got=%b exp=%b", e.tag, e.cyc, act_ctl, e.ctl);
            end
            n_checks++;
            if (act_fwd !== e.fwd) begin
                n_errors++;
                $display("FAIL fwd tag=%0d cyc=%0d got=%b exp=%b", e.tag, e.cyc, act_fwd, e.fwd);
            end
            if (e.chk_cnt) begin
                n_checks++;
                if (bus.stall_cnt !== e.sc) begin
                    n_errors++;
                    $display("FAIL stall_cnt tag=%0d cyc=%0d got=%0d exp=%0d",
                             e.tag, e.cyc, bus.stall_cnt, e.sc);
                end
                n_checks++;
                if (bus.flush_cnt !== e.fc) begin
                    n_errors++;
                    $display("FAIL flush_cnt tag=%0d cyc=%0d got=%0d exp=%0d",
                             e.tag, e.cyc, bus.flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        stim_t r;
        apply(idle());
        rst = 1'b1;
        @(posedge clk);
        #1;

        s = idle(); s.rst = 1'b1;
        step(s, 0); step(s, 0);

        // EX has priority over DM for the same register
        s = idle(); s.rs = 5'd3; s.urs = 1'b1; s.exwb = 1'b1; s.exa = 5'd3;
        s.dmwb = 1'b1; s.dma = 5'd3;
        step(s, 1);

        // load-use on rt, then the load sits in DM
        s = idle(); s.rst = 1'b1; step(s, 2);
        s = idle(); s.rt = 5'd5; s.urt = 1'b1; s.exwb = 1'b1; s.exa = 5'd5; s.exld = 1'b1;
        step(s, 2);
        s = idle(); s.rt = 5'd5; s.urt = 1'b1; s.dmwb = 1'b1; s.dma = 5'd5;
        s.dmld = 1'b1;
        step(s, 2); step(idle(), 2);

        // three cycles of memory wait
        s = idle(); s.rst = 1'b1; step(s, 3);
        s = idle(); s.dmwb = 1'b1; s.dma = 5'd7; s.dmld = 1'b1; s.dmrdy = 1'b0;
        step(s, 3); step(s, 3); step(s, 3);
        s.dmrdy = 1'b1; step(s, 3);
        step(idle(), 3);

        // taken branch interrupted by a two-cycle memory wait
        s = idle(); s.rst = 1'b1; step(s, 4);
        s = idle(); s.br = 1'b1; step(s, 4);
        s = idle(); s.dmld = 1'b1; s.dmrdy = 1'b0; step(s, 4); step(s, 4);
        for (int i = 0; i < 4; i++) step(idle(), 4);

        // r0 is never a hazard or forwarding source
        s = idle(); s.urs = 1'b1; s.urt = 1'b1; s.st = 1'b1;
        s.exwb = 1'b1; s.exld = 1'b1; s.dmwb = 1'b1;
        step(s, 5);

        // counter saturation, then cleared by reset
        s = idle(); s.rst = 1'b1; step(s, 6);
        s = idle(); s.dmld = 1'b1; s.dmrdy = 1'b0;
        for (int i = 0; i < 20; i++) step(s, 6);
        step(idle(), 6);
        s = idle(); s.rst = 1'b1; step(s, 6);
        step(idle(), 6);

        // reset abandons a flush and a memory wait
        s = idle(); s.br = 1'b1; step(s, 7);
        s = idle(); s.rst = 1'b1; step(s, 7);
        step(idle(), 7); step(idle(), 7);
        s = idle(); s.dmld = 1'b1; s.dmrdy = 1'b0; step(s, 7);
        s.rst = 1'b1; step(s, 7);
        step(idle(), 7);

        for (int i = 0; i < 500; i++) begin
            r          = '0;
            r.rst      = ($urandom_range(0, 49) == 0);
            r.id_valid = ($urandom_range(0, 7) != 0);
            r.rs       = RA'($urandom_range(0, 3));
            r.rt       = RA'($urandom_range(0, 3));
            r.urs      = 1'($urandom);
            r.urt      = 1'($urandom);
            r.st       = ($urandom_range(0, 3) == 0);
            r.br       = ($urandom_range(0, 5) == 0);
            r.exwb     = 1'($urandom);
            r.exa      = RA'($urandom_range(0, 3));
            r.exld     = ($urandom_range(0, 2) == 0);
            r.dmwb     = 1'($urandom);
            r.dma      = RA'($urandom_range(0, 3));
            r.dmld     = ($urandom_range(0, 2) == 0);
            r.dmrdy    = ($urandom_range(0, 3) != 0);
            step(r, 8);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
